qam16_byte_packer: RTL
======================

Name: qam16_byte_packer

Overview:
- Sits directly downstream of the RX top-level 16-QAM demapper; consumes its 4-bit symbol stream (out_16qam / out_16qam_vld).
- Pairs consecutive nibbles into bytes, frames them (SYM_PER_FRAME symbols -> SYM_PER_FRAME/2 bytes), and buffers them in a small FIFO.
- Buffered bytes leave through a valid/ready interface toward the MAC/host side, so downstream backpressure never stalls the demapper.

Parameters:
- SYM_PER_FRAME, 64, demapped symbols per OFDM frame; must be even.
- FIFO_DEPTH, 16, output FIFO entries; power of two.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; arms packer for a new frame.
- in_bits  in  4  demapped symbol bits; bit3 is the MSB.
- in_vld  in  1  in_bits valid; no backpressure is offered upstream.
- out_byte  out  8  FIFO head byte.
- out_vld  out  1  FIFO non-empty.
- out_rdy  in  1  downstream accept; a byte transfers when out_vld && out_rdy.
- out_last  out  1  head byte is the final byte of its frame.
- frame_done  out  1  one-cycle pulse when the last byte of a frame is pushed.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- fifo_level  out  FIFO_AW+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst=1, async):
  - FSM goes to S_IDLE; sym_cnt, phase, rd/wr pointers and checksum clear.
  - out_vld=0, out_byte=0, out_last=0, frame_done=0, overflow=0, fifo_level=0.
- FSM states: S_IDLE, S_HI, S_LO, S_CSUM (S_CSUM exists only with the macro), S_DONE.
  - S_IDLE: in_vld is ignored. frame_start -> S_HI.
  - S_HI: in_vld latches in_bits into hi_nib -> S_LO.
  - S_LO: in_vld writes byte {hi_nib, in_bits} to the FIFO on the same edge.
  - After the S_LO write, if it was symbol SYM_PER_FRAME, go to S_DONE (or S_CSUM); otherwise go to S_HI.
  - S_DONE: in_vld is ignored. frame_start -> S_HI.
- sym_cnt counts accepted symbols from 0 to SYM_PER_FRAME-1. The last-byte flag is written into the FIFO alongside the byte (9-bit entry).
- frame_start in any state:
  - Restarts the frame: clears sym_cnt and checksum, discards any held hi_nib, goes to S_HI.
  - FIFO contents are kept.
  - If frame_start and in_vld arrive in the same cycle, frame_start is applied first and that symbol becomes symbol 0 of the new frame (goes to S_LO).
  - overflow is cleared by frame_start.
- FIFO:
  - Show-ahead: out_byte = mem[rd_ptr], out_vld = (level != 0).
  - Latency: byte written on edge k, so out_vld is high from cycle k+1.
  - Push and pop in the same cycle are both honoured and the level is unchanged.
  - A push when full (level == FIFO_DEPTH) with no pop that cycle drops the byte and sets overflow. The dropped byte's last flag is also lost, but frame_done still pulses.
  - A push when full with a simultaneous pop succeeds.
  - Pointers are FIFO_AW bits and wrap naturally.
- frame_done: registered pulse, high for exactly the one cycle after the last byte push (or after the checksum push with the macro).
- out_rdy while out_vld=0 has no effect.
- The output ports are always driven; out_byte and out_last are don't-care while out_vld=0.

Optional Feature:
- Macro: QAM16_PACK_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte of the frame is kept.
  - After the last data byte, the FSM enters S_CSUM for one cycle and pushes the checksum byte, then goes to S_DONE.
  - out_last marks the checksum byte, not the last data byte. A frame produces SYM_PER_FRAME/2+1 bytes.
  - frame_done pulses after the checksum push.
  - in_vld in S_CSUM is ignored; frame_start in S_CSUM aborts the checksum push.
- Undefined: S_CSUM and the XOR register are absent, and a frame is exactly SYM_PER_FRAME/2 bytes.

Test Plan:
- Reset then frame_start, 64 symbols 0x1,0x2,...,0xF,0x0 repeating, out_rdy=1 -> 32 bytes 0x12,0x34,...,0xF0 repeating; out_last on byte 32 only; one frame_done pulse; overflow=0.
- Same stimulus with out_rdy=0 throughout -> fifo_level saturates at 16; overflow sets on byte 17; the first 16 bytes drain intact when out_rdy=1.
- 3 symbols (0xA, 0xB, 0xC), then frame_start, then 0xD, 0xE -> only 0xAB and 0xDE are emitted; the 0xC half-byte is discarded.
- in_vld held high through S_DONE after the frame ends -> no extra bytes; fifo_level is unchanged by the extra symbols.
- rst asserted mid-frame with fifo_level=5 -> all outputs 0 immediately (async); after release, in_vld is ignored until frame_start.
- QAM16_PACK_CHECKSUM_EN, 64 symbols all 0x5 -> 32 bytes 0x55 followed by checksum 0x00 with out_last=1; all 0x5 except the final symbol 0x6 -> last data byte 0x56, checksum 0x03.

Source files
------------

// File: rtl/qam16_byte_packer_if.sv
// Byte-stream output bus of qam16_byte_packer: show-ahead valid/ready with end-of-frame marker.
interface qam16_byte_packer_if;
   logic [7:0] out_byte;
   logic       out_vld;
   logic       out_rdy;
   logic       out_last;

   modport master (output out_byte, output out_vld, output out_last, input out_rdy);
   modport slave  (input out_byte, input out_vld, input out_last, output out_rdy);
endinterface

// File: rtl/qam16_byte_packer.sv
// Packs demapped 16-QAM nibbles into framed bytes and buffers them in a show-ahead FIFO.
// Optional feature: define QAM16_PACK_CHECKSUM_EN to append an XOR checksum byte per frame.
module qam16_byte_packer #(
   parameter int SYM_PER_FRAME = 64,
   parameter int FIFO_DEPTH    = 16,
   parameter int FIFO_AW       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic [3:0]          in_bits,
   input  logic                in_vld,
   qam16_byte_packer_if.master out_if,
   output logic                frame_done,
   output logic                overflow,
   output logic [FIFO_AW:0]    fifo_level
);
   localparam int CW = (SYM_PER_FRAME > 2) ? $clog2(SYM_PER_FRAME) : 1;
   localparam logic [CW-1:0]    LAST_SYM = CW'(SYM_PER_FRAME - 1);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HI   = 3'd1,
      S_LO   = 3'd2,
`ifdef QAM16_PACK_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_sym_cnt, w_sym_cnt_nxt;
   logic [3:0]         r_hi_nib, w_hi_nib_nxt;
   logic               w_push, w_push_last, w_frame_end;
   logic [7:0]         w_push_byte;
`ifdef QAM16_PACK_CHECKSUM_EN
   logic [7:0]         r_csum, w_csum_nxt;
`endif

   logic [8:0]         r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [FIFO_AW:0]   r_level;
   logic               r_overflow, r_frame_done;
   logic               w_pop, w_full, w_wr, w_not_empty;
   logic [8:0]         w_head;

   // frame_start outranks everything, including a symbol arriving on the same cycle
   always_comb begin
      w_state_nxt   = r_state;
      w_sym_cnt_nxt = r_sym_cnt;
      w_hi_nib_nxt  = r_hi_nib;
      w_push        = 1'b0;
      w_push_byte   = 8'h00;
      w_push_last   = 1'b0;
      w_frame_end   = 1'b0;
`ifdef QAM16_PACK_CHECKSUM_EN
      w_csum_nxt    = r_csum;
`endif
      if (frame_start) begin
         w_sym_cnt_nxt = '0;
`ifdef QAM16_PACK_CHECKSUM_EN
         w_csum_nxt    = 8'h00;
`endif
         if (in_vld) begin
            w_hi_nib_nxt  = in_bits;
            w_sym_cnt_nxt = CW'(1);
            w_state_nxt   = S_LO;
         end else begin
            w_state_nxt   = S_HI;
         end
      end else begin
         case (r_state)
            S_HI: begin
               if (in_vld) begin
                  w_hi_nib_nxt  = in_bits;
                  w_sym_cnt_nxt = r_sym_cnt + CW'(1);
                  w_state_nxt   = S_LO;
               end
            end
            S_LO: begin
               if (in_vld) begin
                  w_push      = 1'b1;
                  w_push_byte = {r_hi_nib, in_bits};
`ifdef QAM16_PACK_CHECKSUM_EN
                  w_csum_nxt  = r_csum ^ {r_hi_nib, in_bits};
`endif
                  if (r_sym_cnt == LAST_SYM) begin
                     w_sym_cnt_nxt = '0;
`ifdef QAM16_PACK_CHECKSUM_EN
                     w_state_nxt   = S_CSUM;
`else
                     w_push_last   = 1'b1;
                     w_frame_end   = 1'b1;
                     w_state_nxt   = S_DONE;
`endif
                  end else begin
                     w_sym_cnt_nxt = r_sym_cnt + CW'(1);
                     w_state_nxt   = S_HI;
                  end
               end
            end
`ifdef QAM16_PACK_CHECKSUM_EN
            S_CSUM: begin
               w_push      = 1'b1;
               w_push_byte = r_csum;
               w_push_last = 1'b1;
               w_frame_end = 1'b1;
               w_state_nxt = S_DONE;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_sym_cnt <= '0;
`ifdef QAM16_PACK_CHECKSUM_EN
         r_csum    <= 8'h00;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_sym_cnt <= w_sym_cnt_nxt;
`ifdef QAM16_PACK_CHECKSUM_EN
         r_csum    <= w_csum_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      r_hi_nib <= w_hi_nib_nxt;
   end

   // A full FIFO still accepts a push when the head leaves on the same edge
   assign w_not_empty = (r_level != '0);
   assign w_pop       = out_if.out_rdy && w_not_empty;
   assign w_full      = (r_level == FULL_LVL);
   assign w_wr        = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {w_push_last, w_push_byte};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
            2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
            default: r_level <= r_level;
         endcase
         if (frame_start)          r_overflow <= 1'b0;
         else if (w_push && !w_wr) r_overflow <= 1'b1;
         r_frame_done <= w_frame_end;
      end
   end

   // Head is masked while empty so reset drives the byte outputs to zero at once
   assign w_head          = r_mem[r_rd_ptr];
   assign out_if.out_vld  = w_not_empty;
   assign out_if.out_byte = w_not_empty ? w_head[7:0] : 8'h00;
   assign out_if.out_last = w_not_empty ? w_head[8] : 1'b0;
   assign frame_done      = r_frame_done;
   assign overflow        = r_overflow;
   assign fifo_level      = r_level;
endmodule
